// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe obstacle stream: column encoding, FSM
// states, gap-height width and the default geometry/randomiser constants
// that the renderer and collision logic also import.
package pipe_pkg;

    // Column bit driven into the obstacle shift register
    localparam logic PIPE_COL = 1'b1;
    localparam logic OPEN_COL = 1'b0;

    // Segment currently being emitted
    typedef enum logic {
        GAP  = 1'b0,
        PIPE = 1'b1
    } pipe_state_t;

    localparam int GAP_Y_W = 7;

    // Default geometry
    localparam int DEF_PIPE_WIDTH  = 4;
    localparam int DEF_MIN_SPACING = 8;

    // Fibonacci LFSR: feedback = xor of bits 7,5,4,3, shifted in at the LSB
    localparam logic [7:0] LFSR_TAPS      = 8'b1011_1000;
    localparam logic [7:0] DEF_LFSR_SEED  = 8'hB5;

    // Next LFSR value for a given current value
    function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when asked. Shared by the pipe
// generator and the later bird/powerup randomisers.
module pipe_lfsr8
    import pipe_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       advance,
    output logic [7:0] value
);

    // An all-zero seed would lock the register at zero forever
    generate
        if (SEED == 8'h00) begin : g_bad_seed
            $error("pipe_lfsr8: SEED must be nonzero");
        end
    endgenerate

    // Step the register on each advance request, hold otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr8_next(value);
        end
    end

endmodule

// File: rtl/pipe_pattern_generator.sv
// Serial column source for the 40-bit obstacle shift register. Emits
// PIPE_WIDTH pipe columns followed by a pseudo-random run of open columns,
// publishing each pipe's random gap height on its first column.
//
// Handshake: there is no valid/ready pair. A tick is accepted on any clk
// edge where shift_tick=1 and enable=1; each such cycle is exactly one
// column. Without an accepted tick every register holds, except gap_valid,
// which is a single-cycle strobe and drops back to 0.
module pipe_pattern_generator
    import pipe_pkg::*;
#(
    parameter int         PIPE_WIDTH  = DEF_PIPE_WIDTH,
    parameter int         MIN_SPACING = DEF_MIN_SPACING,
    parameter int         GAP_Y_MIN   = 16,
    parameter logic [7:0] LFSR_SEED   = DEF_LFSR_SEED
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               shift_tick,
    output logic               data_out,
    output logic [GAP_Y_W-1:0] gap_y,
    output logic               gap_valid,
    output logic [7:0]         pipe_count,
    output pipe_state_t        dbg_state,
    output logic [3:0]         dbg_cnt,
    output logic [7:0]         dbg_lfsr
);

    generate
        if (PIPE_WIDTH < 1 || PIPE_WIDTH > 15) begin : g_bad_width
            $error("pipe_pattern_generator: PIPE_WIDTH out of range 1..15");
        end
        if (MIN_SPACING < 1 || MIN_SPACING > 15) begin : g_bad_spacing
            $error("pipe_pattern_generator: MIN_SPACING out of range 1..15");
        end
    endgenerate

    localparam logic [3:0] PW = 4'(PIPE_WIDTH);
    localparam logic [3:0] MS = 4'(MIN_SPACING);

    pipe_state_t        state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [7:0]         lfsr;
    logic               accept;
    logic               first_col;
    logic               data_next;
    logic [GAP_Y_W-1:0] gap_y_next;
    logic               gap_valid_next;
    logic [7:0]         pipe_count_next;

    assign accept = enable & shift_tick;

    // Random source; every field below samples its pre-advance value
    pipe_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .advance(accept),
        .value  (lfsr)
    );

    // State register: segment type and columns left in it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= GAP;
            cnt   <= MS;
        end else if (accept) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: count down, swap segment after its last column
    always_comb begin
        state_next = state;
        cnt_next   = cnt - 4'd1;
        if (cnt == 4'd1) begin
            if (state == GAP) begin
                state_next = PIPE;
                cnt_next   = PW;
            end else begin
                state_next = GAP;
                cnt_next   = MS + {1'b0, lfsr[2:0]};
            end
        end
    end

    // Output decode: column bit, and gap/pipe bookkeeping on a pipe's first column
    always_comb begin
        first_col       = (state == PIPE) && (cnt == PW);
        data_next       = (state == PIPE) ? PIPE_COL : OPEN_COL;
        gap_y_next      = gap_y;
        gap_valid_next  = 1'b0;
        pipe_count_next = pipe_count;
        if (first_col) begin
            gap_y_next      = GAP_Y_W'(GAP_Y_MIN) + {1'b0, lfsr[5:0]};
            gap_valid_next  = 1'b1;
            pipe_count_next = pipe_count + 8'd1;
        end
    end

    // Output registers: update on accepted ticks, strobe self-clears
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out   <= OPEN_COL;
            gap_y      <= '0;
            gap_valid  <= 1'b0;
            pipe_count <= 8'd0;
        end else if (accept) begin
            data_out   <= data_next;
            gap_y      <= gap_y_next;
            gap_valid  <= gap_valid_next;
            pipe_count <= pipe_count_next;
        end else begin
            gap_valid  <= 1'b0;
        end
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;
    assign dbg_lfsr  = lfsr;

endmodule

// File: tb/tb_pipe_pattern_generator.sv
// Bench for pipe_pattern_generator: a column-queue reference model feeds an
// expected queue at tick issue time; a monitor pops and compares after each
// accepted edge and checks that gap_valid stays low on all other cycles.
module tb_pipe_pattern_generator;
    import pipe_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        shift_tick = 1'b0;
    logic        data_out;
    logic [6:0]  gap_y;
    logic        gap_valid;
    logic [7:0]  pipe_count;
    pipe_state_t dbg_state;
    logic [3:0]  dbg_cnt;
    logic [7:0]  dbg_lfsr;

    always #5 clk = ~clk;

    pipe_pattern_generator dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .shift_tick(shift_tick),
        .data_out  (data_out),
        .gap_y     (gap_y),
        .gap_valid (gap_valid),
        .pipe_count(pipe_count),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt),
        .dbg_lfsr  (dbg_lfsr)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       d;
        logic       v;
        logic [6:0] gy;
        logic [7:0] pc;
        logic [3:0] cnt;
        logic [7:0] lf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending columns of the current segment; bit0 = column value, bit1 = first pipe column.
    logic [1:0] m_col_q[$];
    logic [7:0] m_lfsr;
    logic [6:0] m_gy;
    logic [7:0] m_pc;
    int         m_started;
    logic       m_last_d;

    function automatic logic [7:0] ref_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return ((v << 1) & 8'hFF) | {7'd0, fb};
    endfunction

    task automatic model_reset();
        m_col_q.delete();
        for (int i = 0; i < 8; i++) m_col_q.push_back(2'b00);
        m_lfsr    = 8'hB5;
        m_gy      = 7'd0;
        m_pc      = 8'd0;
        m_last_d  = 1'b0;
    endtask

    task automatic model_tick(output exp_t e);
        logic [1:0] col;
        col = m_col_q.pop_front();
        e.v = 1'b0;
        if (col[1]) begin
            m_gy = 7'(16 + (m_lfsr % 64));
            m_pc = m_pc + 8'd1;
            m_started++;
            e.v = 1'b1;
        end
        if (m_col_q.size() == 0) begin
            if (col[0]) begin
                for (int i = 0; i < 8 + (m_lfsr % 8); i++) m_col_q.push_back(2'b00);
            end else begin
                m_col_q.push_back(2'b11);
                for (int i = 1; i < 4; i++) m_col_q.push_back(2'b01);
            end
        end
        m_lfsr   = ref_step(m_lfsr);
        m_last_d = col[0];
        e.d   = col[0];
        e.gy  = m_gy;
        e.pc  = m_pc;
        e.cnt = 4'(m_col_q.size());
        e.lf  = m_lfsr;
    endtask

    // ---------------- monitor ----------------
    logic acc = 1'b0;
    always @(posedge clk) acc = resetn && enable && shift_tick;

    always @(negedge clk) begin
        exp_t e;
        if (acc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out",   {31'd0, data_out},  {31'd0, e.d});
                chk("gap_valid",  {31'd0, gap_valid}, {31'd0, e.v});
                chk("gap_y",      {25'd0, gap_y},     {25'd0, e.gy});
                chk("pipe_count", {24'd0, pipe_count}, {24'd0, e.pc});
                chk("cnt",        {28'd0, dbg_cnt},   {28'd0, e.cnt});
                chk("lfsr",       {24'd0, dbg_lfsr},  {24'd0, e.lf});
            end
        end else if (resetn) begin
            chk("gap_valid_idle", {31'd0, gap_valid}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered shortly after a rising edge.
    task automatic tick_hold(input int n);
        exp_t e;
        enable = 1'b1;
        shift_tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            model_tick(e);
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        shift_tick = 1'b0;
    endtask

    task automatic tick_spaced(input int n);
        for (int i = 0; i < n; i++) begin
            tick_hold(1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic do_reset();
        shift_tick = 1'b0;
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rst_data_out",   {31'd0, data_out},   32'd0);
        chk("rst_gap_y",      {25'd0, gap_y},      32'd0);
        chk("rst_gap_valid",  {31'd0, gap_valid},  32'd0);
        chk("rst_pipe_count", {24'd0, pipe_count}, 32'd0);
        chk("rst_lfsr",       {24'd0, dbg_lfsr},   32'hB5);
        chk("rst_cnt",        {28'd0, dbg_cnt},    32'd8);
        chk("rst_state",      {31'd0, dbg_state},  32'd0);
        if (exp_q.size() != 0) begin
            chk("stale_expect", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] lfsr_tab [0:8];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        lfsr_tab = '{8'hB5, 8'h6B, 8'hD6, 8'hAC, 8'h59, 8'hB2, 8'h65, 8'hCB, 8'h96};
        m_started = 0;
        model_reset();

        // Spaced ticks from reset with directed constants alongside the model
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick_hold(1);
            chk("lfsr_step", {24'd0, dbg_lfsr}, {24'd0, lfsr_tab[i]});
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        tick_hold(1);
        chk("tick9_gap_y", {25'd0, gap_y}, 32'd38);
        chk("tick9_count", {24'd0, pipe_count}, 32'd1);
        tick_spaced(11);
        chk("tick20_data", {31'd0, data_out}, 32'd0);
        tick_hold(1);
        chk("tick21_data", {31'd0, data_out}, 32'd1);
        chk("tick21_count", {24'd0, pipe_count}, 32'd2);
        tick_spaced(30);

        // Freeze mid-pipe: ticks with enable low change nothing
        do_reset();
        tick_spaced(10);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            shift_tick = 1'b1;
            @(posedge clk); #1;
            shift_tick = 1'b0;
            @(posedge clk); #1;
        end
        chk("frz_data",  {31'd0, data_out},   {31'd0, m_last_d});
        chk("frz_cnt",   {28'd0, dbg_cnt},    m_col_q.size());
        chk("frz_lfsr",  {24'd0, dbg_lfsr},   {24'd0, m_lfsr});
        chk("frz_count", {24'd0, pipe_count}, {24'd0, m_pc});
        tick_hold(1);
        chk("resume11", {31'd0, data_out}, 32'd1);
        tick_hold(1);
        chk("resume12", {31'd0, data_out}, 32'd1);
        tick_hold(1);
        chk("resume13", {31'd0, data_out}, 32'd0);

        // shift_tick held high for 12 cycles
        do_reset();
        tick_hold(8);
        chk("held8_data", {31'd0, data_out}, 32'd0);
        tick_hold(4);
        chk("held12_data", {31'd0, data_out}, 32'd1);
        chk("held12_count", {24'd0, pipe_count}, 32'd1);

        // Async reset in the middle of the first pipe
        do_reset();
        tick_spaced(10);
        do_reset();
        tick_spaced(8);
        chk("post_rst_data", {31'd0, data_out}, 32'd0);
        tick_hold(1);
        chk("post_rst_gap_y", {25'd0, gap_y}, 32'd38);

        // Random enable / tick mix
        for (int i = 0; i < 3000; i++) begin
            exp_t e;
            enable     = ($urandom_range(0, 3) != 0);
            shift_tick = $urandom_range(0, 1);
            if (enable && shift_tick) begin
                model_tick(e);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        shift_tick = 1'b0;

        // pipe_count wrap after 256 pipes
        do_reset();
        m_started = 0;
        while (m_started < 256) tick_hold(1);
        chk("wrap_count", {24'd0, pipe_count}, 32'd0);
        chk("wrap_valid", {31'd0, gap_valid}, 32'd1);
        tick_hold(3);

        @(negedge clk);
        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
